// File: rtl/vga_pixel_counter.sv
// vga_pixel_counter: pixel-rate enable plus free-running h/v raster counters
// that feed the VGA sync decoder, with single-cycle line, frame and
// vertical-blanking-start strobes for per-frame game logic updates.
// Optional build macro VGA_FRAME_COUNT_EN adds a 16-bit frame counter;
// without it frame_count is tied to zero and the port stays in place.
module vga_pixel_counter #(
    parameter int unsigned CLK_DIV = 4,    // system clocks per pixel, 1..16
    parameter int unsigned H_TOTAL = 800,  // pixels per line incl. blanking
    parameter int unsigned V_TOTAL = 525,  // lines per frame incl. blanking
    parameter int unsigned HD      = 640,  // visible pixels per line
    parameter int unsigned VD      = 480   // visible lines per frame
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        soft_clear,
    output logic        pixel_tick,
    output logic [9:0]  h_count,
    output logic [9:0]  v_count,
    output logic        line_end,
    output logic        frame_end,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    // Divider width: at least one bit so CLK_DIV=1 still elaborates cleanly.
    localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    HD_LAST  = 10'(HD - 1);
    localparam logic [9:0]    VD_LAST  = 10'(VD - 1);

    logic [DW-1:0] div_cnt;
    logic          div_wrap;
    logic          h_last;
    logic          v_last;

    // Divider terminal count; only meaningful while running.
    always_comb begin
        div_wrap = enable && (div_cnt == DIV_LAST);
    end

    // Clock divider and registered pixel tick; soft_clear outranks enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            pixel_tick <= 1'b0;
        end else if (soft_clear) begin
            div_cnt    <= '0;
            pixel_tick <= 1'b0;
        end else if (enable) begin
            pixel_tick <= div_wrap;
            div_cnt    <= div_wrap ? '0 : div_cnt + DW'(1);
        end else begin
            pixel_tick <= 1'b0;
        end
    end

    // End-of-line / end-of-frame position decodes.
    always_comb begin
        h_last = (h_count == H_LAST);
        v_last = (v_count == V_LAST);
    end

    // Raster counters step once per pixel tick.
    // A tick already on the output when enable drops is still consumed here:
    // its strobes were already visible, and the held divider then resumes on
    // the following pixel, so no pixel is repeated or lost across a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (soft_clear) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pixel_tick) begin
            if (h_last) begin
                h_count <= '0;
                v_count <= v_last ? '0 : v_count + 10'd1;
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end

    // Strobes decoded from registered state, qualified by the pixel tick.
    always_comb begin
        line_end   = pixel_tick && h_last;
        frame_end  = line_end && v_last;
        frame_tick = pixel_tick && (h_count == HD_LAST) && (v_count == VD_LAST);
    end

`ifdef VGA_FRAME_COUNT_EN
    // Frame counter advances on each completed frame, wrapping at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (frame_end && !soft_clear) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_pixel_counter.sv
// Self-checking bench for vga_pixel_counter using a reduced raster
// (20x6 pixels, 16x4 visible, CLK_DIV=4) so full frames run quickly.
module tb_vga_pixel_counter;

    localparam int CD  = 4;
    localparam int HT  = 20;
    localparam int VT  = 6;
    localparam int HDP = 16;
    localparam int VDP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        soft_clear;
    logic        pixel_tick;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        line_end;
    logic        frame_end;
    logic        frame_tick;
    logic [15:0] frame_count;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       le;
        logic       fe;
        logic       ft;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int fails  = 0;
    int edges  = 0;
    int stray  = 0;
    int pix    = 0;
    int fc_exp = 0;
    int last_tick_edge = 0;

    vga_pixel_counter #(
        .CLK_DIV (CD),
        .H_TOTAL (HT),
        .V_TOTAL (VT),
        .HD      (HDP),
        .VD      (VDP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .soft_clear  (soft_clear),
        .pixel_tick  (pixel_tick),
        .h_count     (h_count),
        .v_count     (v_count),
        .line_end    (line_end),
        .frame_end   (frame_end),
        .frame_tick  (frame_tick),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected raster position and strobes for linear pixel index p.
    function automatic exp_t model(int p);
        exp_t e;
        int h;
        int v;
        h    = p % HT;
        v    = (p / HT) % VT;
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.le = (h == HT - 1);
        e.fe = (h == HT - 1) && (v == VT - 1);
        e.ft = (h == HDP - 1) && (v == VDP - 1);
        return e;
    endfunction

    function automatic logic [15:0] exp_fc();
`ifdef VGA_FRAME_COUNT_EN
        return 16'(fc_exp);
`else
        return 16'd0;
`endif
    endfunction

    // Queue the next pixel's expectation, wait (bounded) for the tick, compare.
    task automatic tick(input string tag, output int gap);
        exp_t e;
        logic found;
        exp_q.push_back(model(pix));
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!pixel_tick && (line_end || frame_end || frame_tick)) stray++;
            if (pixel_tick) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, 32'(found), 32'd1);
        e   = exp_q.pop_front();
        gap = edges - last_tick_edge;
        last_tick_edge = edges;
        if (found) begin
            chk({tag, "_pos"}, 32'({h_count, v_count, line_end, frame_end, frame_tick}), 32'(e));
            if (e.fe) fc_exp++;
        end
        pix++;
    endtask

    initial begin
        int gap;
        int prev_le;
        int prev_fe;
        int ft_seen;
        int bad;
        int fc_hold;
        logic [9:0] v0;

        reset = 1'b1;
        enable = 1'b1;
        soft_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tick", 32'(pixel_tick), 32'd0);
        chk("rst_h", 32'(h_count), 32'd0);
        chk("rst_v", 32'(v_count), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_strobes", 32'({line_end, frame_end, frame_tick}), 32'd0);

        // First tick lands exactly CD edges after release, showing h=0.
        reset = 1'b0;
        last_tick_edge = edges;
        pix = 0;
        tick("first", gap);
        chk("first_gap", 32'(gap), 32'(CD));
        @(negedge clk);
        chk("h_after_first", 32'(h_count), 32'd1);
        chk("tick_one_cycle", 32'(pixel_tick), 32'd0);

        // Two full frames: per-pixel scoreboard, spacing of ticks, lines, frames.
        prev_le = -1;
        prev_fe = -1;
        ft_seen = 0;
        while (pix <= 2 * HT * VT) begin
            tick("run", gap);
            chk("tick_gap", 32'(gap), 32'(CD));
            if (line_end) begin
                if (prev_le >= 0) chk("line_period", 32'(edges - prev_le), 32'(HT * CD));
                prev_le = edges;
            end
            if (frame_tick) ft_seen++;
            if (frame_end) begin
                chk("frame_tick_once", 32'(ft_seen), 32'd1);
                ft_seen = 0;
                if (prev_fe >= 0) chk("frame_period", 32'(edges - prev_fe), 32'(HT * VT * CD));
                prev_fe = edges;
            end
        end
        @(negedge clk);
        chk("fc_after_frames", 32'(frame_count), 32'(exp_fc()));

        // Stall for 37 clocks with h=10 mid-pixel (divider at 1).
        while ((pix % HT) != 10) tick("pre_stall", gap);
        @(negedge clk);
        v0 = v_count;
        chk("stall_start_h", 32'(h_count), 32'd10);
        enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            if (pixel_tick || h_count != 10'd10 || v_count != v0) bad++;
        end
        chk("stall_hold", 32'(bad), 32'd0);
        enable = 1'b1;
        last_tick_edge = edges;
        tick("resume", gap);
        chk("resume_gap", 32'(gap), 32'(CD - 1));
        @(negedge clk);
        chk("resume_h_next", 32'(h_count), 32'd11);

        // soft_clear with enable on the frame_end tick; frame_count must not move.
        while ((pix % (HT * VT)) != HT * VT - 1) tick("pre_sc", gap);
        fc_hold = fc_exp;
        tick("sc_tick", gap);
        fc_exp = fc_hold;
        chk("sc_on_frame_end", 32'(frame_end), 32'd1);
        soft_clear = 1'b1;
        @(negedge clk);
        chk("sc_h", 32'(h_count), 32'd0);
        chk("sc_v", 32'(v_count), 32'd0);
        chk("sc_tick_low", 32'(pixel_tick), 32'd0);
        chk("sc_fc_hold", 32'(frame_count), 32'(exp_fc()));
        soft_clear = 1'b0;
        last_tick_edge = edges;
        pix = 0;
        tick("after_sc", gap);
        chk("after_sc_gap", 32'(gap), 32'(CD));

        // soft_clear mid-line at h=6, v=2.
        while (pix != 2 * HT + 6) tick("pre_sc2", gap);
        @(negedge clk);
        chk("sc2_pre_h", 32'(h_count), 32'd6);
        soft_clear = 1'b1;
        @(negedge clk);
        chk("sc2_hv", 32'({h_count, v_count}), 32'd0);
        chk("sc2_tick_low", 32'(pixel_tick), 32'd0);
        soft_clear = 1'b0;
        last_tick_edge = edges;
        pix = 0;
        tick("after_sc2", gap);
        chk("after_sc2_gap", 32'(gap), 32'(CD));

        // Async reset between edges on a tick cycle at h=8, v=3.
        while (pix != 3 * HT + 9) tick("pre_rst", gap);
        #2 reset = 1'b1;
        #1;
        chk("arst_tick", 32'(pixel_tick), 32'd0);
        chk("arst_hv", 32'({h_count, v_count}), 32'd0);
        chk("arst_strobes", 32'({line_end, frame_end, frame_tick}), 32'd0);
        chk("arst_fc", 32'(frame_count), 32'd0);
        fc_exp = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last_tick_edge = edges;
        pix = 0;
        tick("after_rst", gap);
        chk("after_rst_gap", 32'(gap), 32'(CD));

        chk("no_strobe_without_tick", 32'(stray), 32'd0);
        chk("fc_final", 32'(frame_count), 32'(exp_fc()));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
